// File: rtl/sim_controller.sv
// Run-control block for the CPU simulation top: sequences the CPU reset, counts
// run cycles and freezes the CPU on a halt store, a cycle timeout or a stalled PC.
module sim_controller #(
    parameter int                WIDTH        = 32,
    parameter int                RESET_CYCLES = 4,
    parameter int                MAX_CLOCKS   = 100000,
    parameter logic [WIDTH-1:0]  HALT_ADDR    = 32'hFFFF_FFF0,
    parameter int                STALL_LIMIT  = 64
) (
    input  logic             InputClk,
    input  logic             rst,
    input  logic [WIDTH-1:0] AddressBus,
    input  logic [WIDTH-1:0] DataBusOut,
    input  logic [10:0]      ControlBus,
    input  logic [WIDTH-1:0] pc,
    output logic             cpu_rst,
    output logic             cpu_run,
    output logic [WIDTH-1:0] CyclesConsumed,
    output logic             done,
    output logic [1:0]       halt_reason,
    output logic [WIDTH-1:0] exit_code
);

    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] HOLD_LAST  = WIDTH'(RESET_CYCLES - 1);
    localparam logic [WIDTH-1:0] CYCLE_LAST = WIDTH'(MAX_CLOCKS - 1);
    localparam logic [WIDTH-1:0] STALL_LAST = WIDTH'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);
    localparam logic             STALL_EN   = (STALL_LIMIT != 0);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] hold_cnt_reg, hold_cnt_next;
    logic [WIDTH-1:0] stall_cnt_reg, stall_cnt_next;
    logic [WIDTH-1:0] prev_pc_reg, prev_pc_next;
    logic [WIDTH-1:0] cycles_reg, cycles_next;
    logic [WIDTH-1:0] exit_code_reg, exit_code_next;
    logic [1:0]       reason_reg, reason_next;
    logic             cpu_rst_reg, cpu_run_reg, done_reg;

    logic halt_store, timeout, pc_same, stall_hit;

    // Only the write-enable bit of the control bus matters here.
    logic unused_ctrl;
    assign unused_ctrl = ^{ControlBus[10:3], ControlBus[1:0]};

    assign halt_store = ControlBus[2] && (AddressBus == HALT_ADDR);
    assign timeout    = (cycles_reg == CYCLE_LAST);
    assign pc_same    = (pc == prev_pc_reg);
    assign stall_hit  = STALL_EN && pc_same && (stall_cnt_reg == STALL_LAST);

    always_comb begin
        state_next     = state_reg;
        hold_cnt_next  = hold_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        prev_pc_next   = prev_pc_reg;
        cycles_next    = cycles_reg;
        exit_code_next = exit_code_reg;
        reason_next    = reason_reg;
        case (state_reg)
            HOLD: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                cycles_next  = cycles_reg + 1'b1;
                prev_pc_next = pc;
                if (!pc_same) begin
                    stall_cnt_next = '0;
                end else if (stall_cnt_reg != '1) begin
                    stall_cnt_next = stall_cnt_reg + 1'b1;
                end
                // Priority: halt store, then timeout, then stall.
                if (halt_store) begin
                    reason_next    = 2'b01;
                    exit_code_next = DataBusOut;
                    state_next     = DONE;
                end else if (timeout) begin
                    reason_next = 2'b10;
                    state_next  = DONE;
                end else if (stall_hit) begin
                    reason_next = 2'b11;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = HOLD;
            end
        endcase
    end

    always_ff @(posedge InputClk or posedge rst) begin
        if (rst) begin
            state_reg     <= HOLD;
            hold_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            prev_pc_reg   <= '0;
            cycles_reg    <= '0;
            exit_code_reg <= '0;
            reason_reg    <= 2'b00;
            cpu_rst_reg   <= 1'b1;
            cpu_run_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
            prev_pc_reg   <= prev_pc_next;
            cycles_reg    <= cycles_next;
            exit_code_reg <= exit_code_next;
            reason_reg    <= reason_next;
            cpu_rst_reg   <= (state_next == HOLD);
            cpu_run_reg   <= (state_next == RUN);
            done_reg      <= (state_next == DONE);
        end
    end

    assign cpu_rst        = cpu_rst_reg;
    assign cpu_run        = cpu_run_reg;
    assign CyclesConsumed = cycles_reg;
    assign done           = done_reg;
    assign halt_reason    = reason_reg;
    assign exit_code      = exit_code_reg;

endmodule

// File: tb/tb_sim_controller.sv
// Directed bench for sim_controller: reset sequencing, halt store, timeout,
// priority, stall detection, non-terminating accesses and asynchronous reset.
module tb_sim_controller;

    localparam logic [31:0] HALT = 32'hFFFF_FFF0;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data;
    logic [10:0] ctrl;
    logic [31:0] pc;
    logic        cpu_rst;
    logic        cpu_run;
    logic [31:0] cycles;
    logic        done;
    logic [1:0]  halt_reason;
    logic [31:0] exit_code;

    int errors = 0;
    int checks = 0;
    logic [31:0] pc_val = 32'h100;

    sim_controller #(
        .WIDTH(32), .RESET_CYCLES(4), .MAX_CLOCKS(50),
        .HALT_ADDR(HALT), .STALL_LIMIT(8)
    ) dut (
        .InputClk(clk), .rst(rst), .AddressBus(addr), .DataBusOut(data),
        .ControlBus(ctrl), .pc(pc), .cpu_rst(cpu_rst), .cpu_run(cpu_run),
        .CyclesConsumed(cycles), .done(done), .halt_reason(halt_reason),
        .exit_code(exit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU cycle: present the bus values (PC advances unless held) and clock.
    task automatic cyc(input logic [31:0] a, input logic [10:0] c, input logic [31:0] d,
                       input logic hold_pc);
        if (!hold_pc) pc_val = pc_val + 32'd4;
        pc   = pc_val;
        addr = a;
        ctrl = c;
        data = d;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(32'h0, 11'h0, 32'h0, 1'b0);
    endtask

    // Assert rst between edges and check outputs clear before the next edge.
    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #2;
        check({tag, "_rst_cpu_rst"}, {31'b0, cpu_rst}, 32'd1);
        check({tag, "_rst_cpu_run"}, {31'b0, cpu_run}, 32'd0);
        check({tag, "_rst_cycles"},  cycles, 32'd0);
        check({tag, "_rst_done"},    {31'b0, done}, 32'd0);
        check({tag, "_rst_reason"},  {30'b0, halt_reason}, 32'd0);
        check({tag, "_rst_exit"},    exit_code, 32'd0);
    endtask

    // Release rst with a halt store presented throughout HOLD; it must be ignored.
    task automatic release_hold(input string tag);
        rst  = 1'b0;
        addr = HALT;
        ctrl = 11'h004;
        data = 32'h77;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check({tag, "_hold_cpu_rst"}, {31'b0, cpu_rst}, 32'd1);
            check({tag, "_hold_cpu_run"}, {31'b0, cpu_run}, 32'd0);
        end
        tick();
        check({tag, "_run_cpu_rst"}, {31'b0, cpu_rst}, 32'd0);
        check({tag, "_run_cpu_run"}, {31'b0, cpu_run}, 32'd1);
        check({tag, "_run_cycles"},  cycles, 32'd0);
        check({tag, "_run_done"},    {31'b0, done}, 32'd0);
        check({tag, "_run_exit"},    exit_code, 32'd0);
        addr = 32'h0;
        ctrl = 11'h0;
        data = 32'h0;
    endtask

    initial begin
        rst  = 1'b1;
        addr = 32'h0;
        data = 32'h0;
        ctrl = 11'h0;
        pc   = pc_val;
        tick();
        tick();

        $display("scenario: reset sequencing and halt store");
        apply_reset("init");
        release_hold("init");
        idle(3);
        cyc(HALT, 11'h002, 32'h11, 1'b0);           // read of halt address
        cyc(HALT + 32'd4, 11'h004, 32'h22, 1'b0);   // store next to halt address
        idle(5);
        check("pre_halt_done", {31'b0, done}, 32'd0);
        check("pre_halt_cycles", cycles, 32'd10);
        cyc(HALT, 11'h004, 32'h2A, 1'b0);
        check("halt_done", {31'b0, done}, 32'd1);
        check("halt_reason", {30'b0, halt_reason}, 32'd1);
        check("halt_exit", exit_code, 32'h2A);
        check("halt_cycles", cycles, 32'd11);
        check("halt_cpu_run", {31'b0, cpu_run}, 32'd0);
        check("halt_cpu_rst", {31'b0, cpu_rst}, 32'd0);
        for (int i = 0; i < 20; i++) cyc(HALT, 11'h004, 32'h1000 + i, 1'b0);
        check("frozen_cycles", cycles, 32'd11);
        check("frozen_exit", exit_code, 32'h2A);
        check("frozen_reason", {30'b0, halt_reason}, 32'd1);
        check("frozen_done", {31'b0, done}, 32'd1);

        $display("scenario: reset in DONE, then timeout");
        apply_reset("done");
        release_hold("to");
        idle(49);
        check("to_pre_done", {31'b0, done}, 32'd0);
        check("to_pre_cycles", cycles, 32'd49);
        idle(1);
        check("to_done", {31'b0, done}, 32'd1);
        check("to_reason", {30'b0, halt_reason}, 32'd2);
        check("to_cycles", cycles, 32'd50);
        check("to_exit", exit_code, 32'd0);

        $display("scenario: halt store on the timeout cycle");
        apply_reset("prio");
        release_hold("prio");
        idle(49);
        cyc(HALT, 11'h004, 32'h55, 1'b0);
        check("prio_reason", {30'b0, halt_reason}, 32'd1);
        check("prio_exit", exit_code, 32'h55);
        check("prio_cycles", cycles, 32'd50);

        $display("scenario: stall after 8 unchanged cycles");
        apply_reset("st1");
        release_hold("st1");
        idle(5);
        for (int i = 0; i < 7; i++) cyc(32'h0, 11'h0, 32'h0, 1'b1);
        check("st1_pre_done", {31'b0, done}, 32'd0);
        cyc(32'h0, 11'h0, 32'h0, 1'b1);
        check("st1_done", {31'b0, done}, 32'd1);
        check("st1_reason", {30'b0, halt_reason}, 32'd3);
        check("st1_cycles", cycles, 32'd13);

        $display("scenario: PC change at unchanged-count 7 restarts stall count");
        apply_reset("st2");
        release_hold("st2");
        idle(5);
        for (int i = 0; i < 7; i++) cyc(32'h0, 11'h0, 32'h0, 1'b1);
        idle(1);
        for (int i = 0; i < 7; i++) cyc(32'h0, 11'h0, 32'h0, 1'b1);
        check("st2_pre_done", {31'b0, done}, 32'd0);
        check("st2_pre_cycles", cycles, 32'd20);
        cyc(32'h0, 11'h0, 32'h0, 1'b1);
        check("st2_done", {31'b0, done}, 32'd1);
        check("st2_reason", {30'b0, halt_reason}, 32'd3);
        check("st2_cycles", cycles, 32'd21);

        $display("scenario: reset mid-RUN");
        apply_reset("mr0");
        release_hold("mr0");
        idle(6);
        check("mr_cycles", cycles, 32'd6);
        apply_reset("mr");
        release_hold("mr");
        idle(3);
        check("mr_after_cycles", cycles, 32'd3);
        check("mr_after_done", {31'b0, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sim_controller.md
# sim_controller

Synthesisable run-control block for the CPU simulation top. It generates the CPU reset sequence from the external reset and counts consumed cycles. It detects program termination: a store to a halt address, a cycle timeout, or a stalled PC. It then freezes the CPU and latches the exit code and reason, so the testbench and FPGA top share one termination mechanism instead of fixed-delay runs.

## Interface
- `WIDTH`, 32, data/address bus width and counter width
- `RESET_CYCLES`, 4, cycles `cpu_rst` stays high after `rst` falls (≥1)
- `MAX_CLOCKS`, 100000, run-cycle timeout (≥1, < 2^WIDTH)
- `HALT_ADDR`, 32'hFFFF_FFF0, store address that terminates the program
- `STALL_LIMIT`, 64, consecutive cycles with unchanged PC that count as a hang (0 disables)

- `InputClk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `AddressBus`  in  WIDTH  CPU data address
- `DataBusOut`  in  WIDTH  CPU store data
- `ControlBus`  in  11  CPU memory control; bit 2 = MemWriteEn, bit 1 = MemReadEn
- `pc`  in  WIDTH  CPU current PC
- `cpu_rst`  out  1  reset to CPU
- `cpu_run`  out  1  CPU clock-enable
- `CyclesConsumed`  out  WIDTH  run cycles counted
- `done`  out  1  program terminated
- `halt_reason`  out  2  00 none, 01 halt store, 10 timeout, 11 stall
- `exit_code`  out  WIDTH  store data captured on halt store

## Operation
- FSM states: HOLD, RUN, DONE.
- HOLD:
  - `cpu_rst`=1, `cpu_run`=0.
  - `hold_cnt` counts to RESET_CYCLES-1, then → RUN.
- RUN:
  - `cpu_rst`=0, `cpu_run`=1.
  - `CyclesConsumed` increments each cycle.
- RUN termination checks, evaluated every cycle, priority high to low:
  1. Halt store: `ControlBus[2]` && `AddressBus`==HALT_ADDR → `exit_code`←`DataBusOut`, reason 01.
  2. Timeout: `CyclesConsumed`==MAX_CLOCKS-1 on this cycle → reason 10.
  3. Stall: `stall_cnt` reaches STALL_LIMIT-1 with `pc` equal to the previous `pc` → reason 11.
- Any termination → DONE in the same edge. `CyclesConsumed` takes its incremented value on that edge, so the terminating cycle is counted.
- `stall_cnt`:
  - Clears whenever `pc` differs from the registered previous PC.
  - Otherwise increments, saturating.
  - The previous-PC register loads every RUN cycle.
- DONE:
  - `cpu_run`=0, `cpu_rst`=0.
  - `done`=1.
  - Counter, `exit_code` and `halt_reason` are frozen.
  - Leaves DONE only via `rst`.
- A read (`ControlBus[1]`) of HALT_ADDR does not terminate.
- A halt store in HOLD is ignored.
- All widths are WIDTH; the counter never wraps because timeout fires first.

## Timing
- Reset values while `rst`=1 (asynchronous):
  - FSM = HOLD.
  - `cpu_rst`=1, `cpu_run`=0.
  - `CyclesConsumed`=0, `done`=0, `halt_reason`=00, `exit_code`=0.
  - `hold_cnt`=0, `stall_cnt`=0.
- `cpu_rst` falls RESET_CYCLES rising edges after `rst` deasserts. The first edge at which `rst` is already low counts as edge 1.
- Termination latency: outputs update at the rising edge that samples the terminating condition; `done` is visible one cycle after that condition is presented.
- Simultaneous halt store and timeout on the same cycle → reason 01 with `exit_code` captured.
- `rst` asserted mid-RUN or in DONE → immediate return to the reset values; the full HOLD sequence repeats.
- All outputs are registered.

## Test plan
- Reset sequencing: RESET_CYCLES=4; release `rst` → `cpu_rst` high for exactly 4 edges, then `cpu_run`=1 and the counter starts from 0.
- Halt store: after 10 RUN cycles, `ControlBus[2]`=1, `AddressBus`=HALT_ADDR, `DataBusOut`=0x2A → `done`=1, `halt_reason`=01, `exit_code`=0x2A, `CyclesConsumed`=11, and the values remain frozen for 20 further cycles.
- Timeout and priority:
  - MAX_CLOCKS=50 with no halt → `halt_reason`=10 and `CyclesConsumed`=50.
  - Rerun with the halt store presented on cycle 50 → reason 01.
- Stall: STALL_LIMIT=8; `pc` changes each cycle, then is held constant → `halt_reason`=11 on the 8th consecutive unchanged cycle. A PC change at unchanged-count 7 resets the count and produces no halt.
- Non-terminating accesses:
  - A read of HALT_ADDR does not terminate.
  - A store to HALT_ADDR+4 does not terminate.
  - A store to HALT_ADDR during HOLD is ignored.
- Reset mid-run: assert `rst` asynchronously between edges during RUN and during DONE → all outputs return to their reset values immediately (before the next edge); the HOLD sequence repeats.
